run_sequencer: RTL and testbench
================================

# run_sequencer

Parametrised run-control block between the testbench start/ack handshake and the 9-bit-ISA core. It arms on `start`, launches the core at a selectable program base address, gates the core with `run_en`, counts execution cycles, and reports completion through `ack` on core halt or cycle-budget timeout. Supports `NUM_PROGS` independent programs and back-to-back runs without reset.

## Interface

Parameters:
- `PC_WIDTH`, 10: width of the program counter load value.
- `CYCLE_WIDTH`, 16: width of the cycle counter.
- `TIMEOUT`, 4096: maximum RUN cycles before forced completion; legal range 1 to 2^CYCLE_WIDTH−1.
- `NUM_PROGS`, 3: number of selectable programs.
- `SEL_WIDTH`, 2: width of `prog_sel`; must satisfy 2^SEL_WIDTH ≥ NUM_PROGS.

Ports:
- `clk`  in  1  clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  testbench start level.
- `prog_sel`  in  SEL_WIDTH  program index, sampled on the rising edge of `start`.
- `prog_base`  in  NUM_PROGS*PC_WIDTH  packed base addresses; entry i at bits [i*PC_WIDTH +: PC_WIDTH].
- `done_in`  in  1  halt instruction decoded by the core; valid only while `run_en`=1.
- `run_en`  out  1  core executes; when 0, the core substitutes NOP.
- `pc_load`  out  1  one-cycle strobe that loads `pc_load_val` into the PC.
- `pc_load_val`  out  PC_WIDTH  base address of the selected program.
- `ack`  out  1  run complete.
- `timeout`  out  1  last run ended by budget exhaustion.
- `cycle_count`  out  CYCLE_WIDTH  RUN cycles consumed by the current or last run.
- `busy`  out  1  state is LOAD or RUN.

## Operation

- States: IDLE, ARMED, LOAD, RUN, DONE. All outputs are registered or decoded from the state only. There is no combinational path from any input to any output.
- IDLE: `start`=1 → ARMED. Latch `prog_sel` into `sel_q`.
- ARMED: hold while `start`=1. `start`=0 → LOAD.
- LOAD: `pc_load`=1 for exactly this cycle. `pc_load_val` = `prog_base` entry `sel_q`. If `sel_q` ≥ NUM_PROGS, `pc_load_val`=0. Clear `cycle_count` and `timeout`. Next state is always RUN.
- RUN: `run_en`=1. `cycle_count` increments by 1 every RUN cycle, including the cycle in which the run ends.
  - `done_in`=1 → DONE with `timeout`=0.
  - Otherwise, if `cycle_count` == TIMEOUT−1 → DONE with `timeout`=1.
  - If both conditions hold in the same cycle, `done_in` wins and `timeout`=0.
- DONE: `ack`=1 and `run_en`=0. `cycle_count` and `timeout` are frozen.
  - Rising `start` (`start`=1 while in DONE) → ARMED. Latch a new `prog_sel`. `ack` drops in that same transition.
  - `cycle_count` and `timeout` keep their values until the next LOAD.
- `start` activity in LOAD or RUN is ignored. A run cannot be aborted except by `reset`.
- `done_in` outside RUN is ignored.
- `cycle_count` never wraps. It is bounded by TIMEOUT ≤ 2^CYCLE_WIDTH−1.

## Timing

- Reset values: state=IDLE; `run_en`=0, `pc_load`=0, `pc_load_val`=0, `ack`=0, `timeout`=0, `cycle_count`=0, `busy`=0, `sel_q`=0.
- Reset mid-run: on the next edge all outputs return to their reset values and the state goes to IDLE. `start` held high across reset deassertion arms the block on the first edge after reset.
- Cycle N with `start` falling (sampled 0 in ARMED) → LOAD at N+1 → first RUN cycle at N+2.
- `done_in` sampled 1 at RUN edge M → `ack`=1 from M+1.
- A run of k RUN cycles leaves `cycle_count`=k.
- A timed-out run leaves `cycle_count`=TIMEOUT, with `ack` and `timeout` asserted together.
- `pc_load` and the first `run_en` never overlap. The core sees the new PC on its first RUN cycle.

## Test plan

- Reset, `prog_sel`=1, `prog_base`={30,20,0}, pulse `start` for 3 cycles, assert `done_in` on the 5th RUN cycle → `pc_load` for 1 cycle with `pc_load_val`=20, then `ack`=1, `cycle_count`=5, `timeout`=0.
- TIMEOUT=16, `done_in` never asserted → `ack`=1 and `timeout`=1 after exactly 16 RUN cycles, `cycle_count`=16, `run_en` falls in the same cycle.
- TIMEOUT=16, `done_in`=1 on RUN cycle 16 → `timeout`=0, `cycle_count`=16.
- Back-to-back runs: after DONE, raise `start` with `prog_sel`=2 → `ack` drops on the next edge, second run loads 30, `cycle_count` restarts from 0.
- `prog_sel`=3 with NUM_PROGS=3 → `pc_load_val`=0 and the run completes normally. Toggling `start` during RUN → no state change.
- `reset` asserted on RUN cycle 3 → next edge: IDLE, all outputs 0. Subsequent `start` pulse runs normally.

Source files
------------

// File: rtl/run_sequencer.sv
// Run-control sequencer: arms on start, loads the selected program base into the core PC,
// gates execution with run_en, counts RUN cycles and acks on halt or cycle-budget timeout.
module run_sequencer #(
    parameter int PC_WIDTH    = 10,
    parameter int CYCLE_WIDTH = 16,
    parameter int TIMEOUT     = 4096,
    parameter int NUM_PROGS   = 3,
    parameter int SEL_WIDTH   = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [SEL_WIDTH-1:0]          prog_sel,
    input  logic [NUM_PROGS*PC_WIDTH-1:0] prog_base,
    input  logic                          done_in,
    output logic                          run_en,
    output logic                          pc_load,
    output logic [PC_WIDTH-1:0]           pc_load_val,
    output logic                          ack,
    output logic                          timeout,
    output logic [CYCLE_WIDTH-1:0]        cycle_count,
    output logic                          busy
);

    typedef enum logic [2:0] {
        IDLE,
        ARMED,
        LOAD,
        RUN,
        DONE
    } state_t;

    localparam int NUM_SLOTS = 2 ** SEL_WIDTH;
    localparam logic [CYCLE_WIDTH-1:0] LAST_CYCLE = CYCLE_WIDTH'(TIMEOUT - 1);

    state_t                 state_q, state_d;
    logic [SEL_WIDTH-1:0]   sel_q, sel_d;
    logic [PC_WIDTH-1:0]    pc_load_val_q, pc_load_val_d;
    logic [CYCLE_WIDTH-1:0] cycle_count_q, cycle_count_d;
    logic                   timeout_q, timeout_d;

    // Every selector code has a table slot; codes beyond NUM_PROGS load address 0.
    logic [PC_WIDTH-1:0] base_tbl [NUM_SLOTS];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SLOTS; gi++) begin : g_base
            if (gi < NUM_PROGS) begin : g_valid
                assign base_tbl[gi] = prog_base[gi*PC_WIDTH +: PC_WIDTH];
            end else begin : g_invalid
                assign base_tbl[gi] = '0;
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            sel_q         <= '0;
            pc_load_val_q <= '0;
            cycle_count_q <= '0;
            timeout_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            sel_q         <= sel_d;
            pc_load_val_q <= pc_load_val_d;
            cycle_count_q <= cycle_count_d;
            timeout_q     <= timeout_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        sel_d         = sel_q;
        pc_load_val_d = pc_load_val_q;
        cycle_count_d = cycle_count_q;
        timeout_d     = timeout_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = ARMED;
                    sel_d   = prog_sel;
                end
            end
            ARMED: begin
                // Base is captured here so it is already stable while pc_load is high.
                if (!start) begin
                    state_d       = LOAD;
                    pc_load_val_d = base_tbl[sel_q];
                end
            end
            LOAD: begin
                state_d       = RUN;
                cycle_count_d = '0;
                timeout_d     = 1'b0;
            end
            RUN: begin
                cycle_count_d = cycle_count_q + CYCLE_WIDTH'(1);
                if (done_in) begin
                    state_d = DONE;
                end else if (cycle_count_q == LAST_CYCLE) begin
                    state_d   = DONE;
                    timeout_d = 1'b1;
                end
            end
            DONE: begin
                if (start) begin
                    state_d = ARMED;
                    sel_d   = prog_sel;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign run_en      = (state_q == RUN);
    assign pc_load     = (state_q == LOAD);
    assign ack         = (state_q == DONE);
    assign busy        = (state_q == LOAD) || (state_q == RUN);
    assign pc_load_val = pc_load_val_q;
    assign cycle_count = cycle_count_q;
    assign timeout     = timeout_q;

endmodule

// File: tb/tb_run_sequencer.sv
// Directed testbench for run_sequencer: start/ack handshake, program select, halt, timeout,
// back-to-back runs and mid-run reset, with hand-computed expectations.
module tb_run_sequencer;

    localparam int PC_WIDTH    = 10;
    localparam int CYCLE_WIDTH = 16;
    localparam int TIMEOUT     = 16;
    localparam int NUM_PROGS   = 3;
    localparam int SEL_WIDTH   = 2;

    logic                          clk = 1'b0;
    logic                          reset;
    logic                          start;
    logic [SEL_WIDTH-1:0]          prog_sel;
    logic [NUM_PROGS*PC_WIDTH-1:0] prog_base;
    logic                          done_in;
    logic                          run_en;
    logic                          pc_load;
    logic [PC_WIDTH-1:0]           pc_load_val;
    logic                          ack;
    logic                          timeout;
    logic [CYCLE_WIDTH-1:0]        cycle_count;
    logic                          busy;

    int checks   = 0;
    int failures = 0;

    run_sequencer #(
        .PC_WIDTH   (PC_WIDTH),
        .CYCLE_WIDTH(CYCLE_WIDTH),
        .TIMEOUT    (TIMEOUT),
        .NUM_PROGS  (NUM_PROGS),
        .SEL_WIDTH  (SEL_WIDTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .prog_sel   (prog_sel),
        .prog_base  (prog_base),
        .done_in    (done_in),
        .run_en     (run_en),
        .pc_load    (pc_load),
        .pc_load_val(pc_load_val),
        .ack        (ack),
        .timeout    (timeout),
        .cycle_count(cycle_count),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Advance one clock; inputs and observations both happen 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Hold start for 'hold' edges with the given selector, then drop it; returns in the LOAD cycle.
    task automatic arm_and_load(input logic [SEL_WIDTH-1:0] sel, input int hold);
        prog_sel = sel;
        start    = 1'b1;
        repeat (hold) tick();
        start = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        checks++;
        if ({run_en, pc_load, ack, timeout, busy} !== 5'b0) begin
            failures++;
            $display("FAIL reset_flags: got %b expected 00000", {run_en, pc_load, ack, timeout, busy});
        end
        checks++;
        if (pc_load_val !== 10'd0) begin
            failures++;
            $display("FAIL reset_pc_load_val: got %0d expected 0", pc_load_val);
        end
        checks++;
        if (cycle_count !== 16'd0) begin
            failures++;
            $display("FAIL reset_cycle_count: got %0d expected 0", cycle_count);
        end
        reset = 1'b0;
        tick();
        $display("test_reset: outputs cleared");
    endtask

    task automatic test_basic_run();
        arm_and_load(2'd1, 3);
        checks++;
        if ({pc_load, run_en, busy} !== 3'b101 || pc_load_val !== 10'd20) begin
            failures++;
            $display("FAIL basic_load: pc_load/run_en/busy=%b val=%0d expected 101 val=20",
                     {pc_load, run_en, busy}, pc_load_val);
        end
        tick();
        checks++;
        if ({pc_load, run_en} !== 2'b01 || cycle_count !== 16'd0) begin
            failures++;
            $display("FAIL basic_first_run: pc_load/run_en=%b count=%0d expected 01 count=0",
                     {pc_load, run_en}, cycle_count);
        end
        repeat (4) tick();
        done_in = 1'b1;
        tick();
        done_in = 1'b0;
        checks++;
        if ({ack, run_en, timeout, busy} !== 4'b1000 || cycle_count !== 16'd5) begin
            failures++;
            $display("FAIL basic_done: ack/run_en/timeout/busy=%b count=%0d expected 1000 count=5",
                     {ack, run_en, timeout, busy}, cycle_count);
        end
        $display("test_basic_run: sel=1 val=%0d count=%0d ack=%b", pc_load_val, cycle_count, ack);
    endtask

    task automatic test_timeout();
        arm_and_load(2'd0, 1);
        tick();
        repeat (15) tick();
        checks++;
        if ({run_en, ack} !== 2'b10 || cycle_count !== 16'd15) begin
            failures++;
            $display("FAIL timeout_last_run: run_en/ack=%b count=%0d expected 10 count=15",
                     {run_en, ack}, cycle_count);
        end
        tick();
        checks++;
        if ({ack, timeout, run_en} !== 3'b110 || cycle_count !== 16'd16) begin
            failures++;
            $display("FAIL timeout_end: ack/timeout/run_en=%b count=%0d expected 110 count=16",
                     {ack, timeout, run_en}, cycle_count);
        end
        done_in = 1'b1;
        repeat (2) tick();
        done_in = 1'b0;
        checks++;
        if ({ack, timeout} !== 2'b11 || cycle_count !== 16'd16) begin
            failures++;
            $display("FAIL timeout_frozen: ack/timeout=%b count=%0d expected 11 count=16",
                     {ack, timeout}, cycle_count);
        end
        $display("test_timeout: count=%0d timeout=%b", cycle_count, timeout);
    endtask

    task automatic test_done_at_limit();
        arm_and_load(2'd1, 1);
        tick();
        repeat (15) tick();
        done_in = 1'b1;
        tick();
        done_in = 1'b0;
        checks++;
        if ({ack, timeout} !== 2'b10 || cycle_count !== 16'd16) begin
            failures++;
            $display("FAIL done_at_limit: ack/timeout=%b count=%0d expected 10 count=16",
                     {ack, timeout}, cycle_count);
        end
        $display("test_done_at_limit: count=%0d timeout=%b", cycle_count, timeout);
    endtask

    task automatic test_back_to_back();
        prog_sel = 2'd2;
        start    = 1'b1;
        tick();
        checks++;
        if ({ack, busy} !== 2'b00 || cycle_count !== 16'd16) begin
            failures++;
            $display("FAIL b2b_rearm: ack/busy=%b count=%0d expected 00 count=16",
                     {ack, busy}, cycle_count);
        end
        start = 1'b0;
        tick();
        checks++;
        if (pc_load !== 1'b1 || pc_load_val !== 10'd30) begin
            failures++;
            $display("FAIL b2b_load: pc_load=%b val=%0d expected 1 val=30", pc_load, pc_load_val);
        end
        tick();
        checks++;
        if (run_en !== 1'b1 || cycle_count !== 16'd0) begin
            failures++;
            $display("FAIL b2b_restart: run_en=%b count=%0d expected 1 count=0", run_en, cycle_count);
        end
        repeat (2) tick();
        done_in = 1'b1;
        tick();
        done_in = 1'b0;
        checks++;
        if ({ack, timeout} !== 2'b10 || cycle_count !== 16'd3) begin
            failures++;
            $display("FAIL b2b_done: ack/timeout=%b count=%0d expected 10 count=3",
                     {ack, timeout}, cycle_count);
        end
        $display("test_back_to_back: val=30 count=%0d ack=%b", cycle_count, ack);
    endtask

    task automatic test_bad_sel_and_start_toggle();
        arm_and_load(2'd3, 2);
        checks++;
        if (pc_load !== 1'b1 || pc_load_val !== 10'd0) begin
            failures++;
            $display("FAIL bad_sel_load: pc_load=%b val=%0d expected 1 val=0", pc_load, pc_load_val);
        end
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        checks++;
        if ({run_en, busy, ack} !== 3'b110 || cycle_count !== 16'd2) begin
            failures++;
            $display("FAIL start_in_run: run_en/busy/ack=%b count=%0d expected 110 count=2",
                     {run_en, busy, ack}, cycle_count);
        end
        done_in = 1'b1;
        tick();
        done_in = 1'b0;
        checks++;
        if ({ack, timeout} !== 2'b10 || cycle_count !== 16'd3) begin
            failures++;
            $display("FAIL bad_sel_done: ack/timeout=%b count=%0d expected 10 count=3",
                     {ack, timeout}, cycle_count);
        end
        $display("test_bad_sel_and_start_toggle: count=%0d ack=%b", cycle_count, ack);
    endtask

    task automatic test_reset_mid_run();
        arm_and_load(2'd1, 1);
        repeat (3) tick();
        reset = 1'b1;
        start = 1'b1;
        tick();
        checks++;
        if ({run_en, pc_load, ack, timeout, busy} !== 5'b0 || pc_load_val !== 10'd0 ||
            cycle_count !== 16'd0) begin
            failures++;
            $display("FAIL reset_mid_run: flags=%b val=%0d count=%0d expected 00000 val=0 count=0",
                     {run_en, pc_load, ack, timeout, busy}, pc_load_val, cycle_count);
        end
        reset = 1'b0;
        tick();
        start = 1'b0;
        tick();
        checks++;
        if (pc_load !== 1'b1 || pc_load_val !== 10'd20) begin
            failures++;
            $display("FAIL reset_rearm_load: pc_load=%b val=%0d expected 1 val=20", pc_load, pc_load_val);
        end
        tick();
        done_in = 1'b1;
        tick();
        done_in = 1'b0;
        checks++;
        if ({ack, timeout} !== 2'b10 || cycle_count !== 16'd1) begin
            failures++;
            $display("FAIL reset_rerun_done: ack/timeout=%b count=%0d expected 10 count=1",
                     {ack, timeout}, cycle_count);
        end
        $display("test_reset_mid_run: rerun count=%0d ack=%b", cycle_count, ack);
    endtask

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        prog_sel  = '0;
        prog_base = {10'd30, 10'd20, 10'd0};
        done_in   = 1'b0;
        test_reset();
        test_basic_run();
        test_timeout();
        test_done_at_limit();
        test_back_to_back();
        test_bad_sel_and_start_toggle();
        test_reset_mid_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
